// File: rtl/dpll_dco_if.sv
// Control-word handshake between the loop filter (master) and the DCO (slave).
interface dpll_dco_if #(
    parameter int unsigned ACC_W = 16
);
    logic [ACC_W-1:0] fcw_in;
    logic             fcw_valid;
    logic             fcw_ready;

    modport master (output fcw_in, output fcw_valid, input  fcw_ready);
    modport slave  (input  fcw_in, input  fcw_valid, output fcw_ready);
endinterface

// File: rtl/dpll_dco.sv
// Phase-accumulator DCO producing the DPLL feedback clock; new words take effect only at wrap.
// Optional macro DCO_SLEW_LIMIT_EN limits each applied step to SLEW_MAX.
module dpll_dco #(
    parameter int unsigned      ACC_W    = 16,
    parameter logic [ACC_W-1:0] FCW_INIT = 16'h0800,
    parameter logic [ACC_W-1:0] FCW_MIN  = 16'h0010,
    parameter logic [ACC_W-1:0] FCW_MAX  = 16'h4000,
    parameter int unsigned      PH_W     = 4
`ifdef DCO_SLEW_LIMIT_EN
    ,
    parameter logic [ACC_W-1:0] SLEW_MAX = 16'h0100
`endif
) (
    input  logic             clk_ref,
    input  logic             rst,
    dpll_dco_if.slave        fcw_bus,
    output logic             clk_fb,
    output logic             fb_rise,
    output logic [ACC_W-1:0] fcw_cur,
    output logic [PH_W-1:0]  phase_out
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] pend_fcw_r;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             carry_s;
    logic [ACC_W-1:0] next_fcw_s;

    function automatic logic [ACC_W-1:0] clamp_fcw(input logic [ACC_W-1:0] w);
        logic [ACC_W-1:0] r;
        if (w < FCW_MIN) begin
            r = FCW_MIN;
        end else if (w > FCW_MAX) begin
            r = FCW_MAX;
        end else begin
            r = w;
        end
        return r;
    endfunction

`ifdef DCO_SLEW_LIMIT_EN
    function automatic logic [ACC_W-1:0] slew_step(input logic [ACC_W-1:0] cur,
                                                   input logic [ACC_W-1:0] tgt);
        logic [ACC_W-1:0] r;
        if (tgt > cur) begin
            if ((tgt - cur) > SLEW_MAX) r = cur + SLEW_MAX;
            else                        r = tgt;
        end else begin
            if ((cur - tgt) > SLEW_MAX) r = cur - SLEW_MAX;
            else                        r = tgt;
        end
        return r;
    endfunction
`endif

    // Accumulator adder with carry-out marking the wrap point and the word to apply there.
    always_comb begin
        sum_s      = {1'b0, acc_r} + {1'b0, fcw_cur};
        acc_next_s = sum_s[ACC_W-1:0];
        carry_s    = sum_s[ACC_W];
`ifdef DCO_SLEW_LIMIT_EN
        next_fcw_s = slew_step(fcw_cur, pend_fcw_r);
`else
        next_fcw_s = pend_fcw_r;
`endif
    end

    assign fcw_bus.fcw_ready = (state_r == ST_IDLE);

    // Accumulator, registered clock taps and the pending-word state machine.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            acc_r      <= {ACC_W{1'b0}};
            pend_fcw_r <= FCW_INIT;
            fcw_cur    <= FCW_INIT;
            clk_fb     <= 1'b0;
            fb_rise    <= 1'b0;
            phase_out  <= {PH_W{1'b0}};
        end else begin
            acc_r     <= acc_next_s;
            clk_fb    <= acc_next_s[ACC_W-1];
            fb_rise   <= ~acc_r[ACC_W-1] & acc_next_s[ACC_W-1];
            phase_out <= acc_next_s[ACC_W-1 -: PH_W];
            case (state_r)
                ST_IDLE: begin
                    if (fcw_bus.fcw_valid) begin
                        pend_fcw_r <= clamp_fcw(fcw_bus.fcw_in);
                        state_r    <= ST_PENDING;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    // Only at wrap, so the current period always completes at its old rate.
                    if (carry_s) begin
                        fcw_cur <= next_fcw_s;
                        if (next_fcw_s == pend_fcw_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_PENDING;
                        end
                    end else begin
                        state_r <= ST_PENDING;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
